// File: rtl/ioctl_upload_streamer.sv
// Streams core-side RAM bytes back to the HPS over the ioctl upload port; fixed MEM_LAT read path.
// Latency: MEM_LAT+2 cycles in-range, 2 cycles out-of-range; ioctl_wait is the only backpressure. Optional CRC via UPLOAD_CRC_EN.
module ioctl_upload_streamer #(
    parameter int          AW       = 16,
    parameter int          MEM_LAT  = 1,
    parameter int          IMG_SIZE = 256,
    parameter logic [7:0]  FILL     = 8'hFF
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          ioctl_upload,
    input  logic          ioctl_rd,
    input  logic [24:0]   ioctl_addr,
    output logic [7:0]    ioctl_din,
    output logic          ioctl_wait,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    input  logic [7:0]    mem_q,
    output logic [AW:0]   bytes_sent,
    output logic          done,
    output logic          err
`ifdef UPLOAD_CRC_EN
    ,
    output logic [15:0]   crc
`endif
);

    typedef enum logic [1:0] {IDLE, FETCH, LAT, HOLD} state_t;

    localparam logic [24:0] IMG_LIM  = 25'(IMG_SIZE);
    localparam logic [1:0]  LAT_INIT = 2'(MEM_LAT - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [7:0]    din_q, din_d;
    logic          wait_q, wait_d;
    logic [AW:0]   bytes_q, bytes_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          upload_q;
    logic          rise, fall;
`ifdef UPLOAD_CRC_EN
    logic [15:0]   crc_q, crc_d;

    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {b, 8'h00};
        for (int i = 0; i < 8; i++) begin
            r = r[15] ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
        end
        return r;
    endfunction
`endif

    assign rise = ioctl_upload & ~upload_q;
    assign fall = ~ioctl_upload & upload_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        din_d   = din_q;
        wait_d  = wait_q;
        bytes_d = bytes_q;
        done_d  = 1'b0;
        err_d   = err_q;
`ifdef UPLOAD_CRC_EN
        crc_d   = crc_q;
`endif
        if (rise) begin
            bytes_d = '0;
            err_d   = 1'b0;
`ifdef UPLOAD_CRC_EN
            crc_d   = 16'hFFFF;
`endif
        end
        if (fall) begin
            done_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (ioctl_upload && ioctl_rd) begin
                    addr_d = ioctl_addr[AW-1:0];
                    wait_d = 1'b1;
                    // Range check uses the full 25-bit address before truncation.
                    if (ioctl_addr >= IMG_LIM) begin
                        din_d   = FILL;
                        state_d = HOLD;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            FETCH: begin
                cnt_d   = LAT_INIT;
                state_d = LAT;
            end
            LAT: begin
                if (cnt_q == 2'd0) begin
                    din_d   = mem_q;
                    wait_d  = 1'b0;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            HOLD: begin
                wait_d = 1'b0;
                if (bytes_q != '1) begin
                    bytes_d = bytes_q + 1'b1;
                end
`ifdef UPLOAD_CRC_EN
                crc_d = crc_byte(crc_q, din_q);
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (ioctl_upload && ioctl_rd && (state_q != IDLE)) begin
            err_d = 1'b1;
        end

        // Session dropped while a read is in flight: discard it without counting.
        if (fall && ((state_q == FETCH) || (state_q == LAT))) begin
            state_d = IDLE;
            wait_d  = 1'b0;
            din_d   = din_q;
            cnt_d   = cnt_q;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            din_q    <= '0;
            wait_q   <= 1'b0;
            bytes_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            upload_q <= 1'b0;
`ifdef UPLOAD_CRC_EN
            crc_q    <= 16'hFFFF;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            din_q    <= din_d;
            wait_q   <= wait_d;
            bytes_q  <= bytes_d;
            done_q   <= done_d;
            err_q    <= err_d;
            upload_q <= ioctl_upload;
`ifdef UPLOAD_CRC_EN
            crc_q    <= crc_d;
`endif
        end
    end

    assign mem_rd     = (state_q == FETCH) && ioctl_upload;
    assign mem_addr   = addr_q;
    assign ioctl_din  = din_q;
    assign ioctl_wait = wait_q;
    assign bytes_sent = bytes_q;
    assign done       = done_q;
    assign err        = err_q;
`ifdef UPLOAD_CRC_EN
    assign crc        = crc_q;
`endif

endmodule

// File: tb/tb_ioctl_upload_streamer.sv
// Directed bench for ioctl_upload_streamer: instance A uses MEM_LAT=1, instance B uses MEM_LAT=3.
// Both share stimulus; each has its own RAM model that returns a marker byte when not strobed.
module tb_ioctl_upload_streamer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        upload = 1'b0;
    logic        rd = 1'b0;
    logic [24:0] addr = '0;

    logic [7:0]  din_a, din_b, q_a, q_b;
    logic        wait_a, wait_b, rd_a, rd_b, done_a, done_b, err_a, err_b;
    logic [15:0] ma_a, ma_b;
    logic [16:0] bytes_a, bytes_b;
`ifdef UPLOAD_CRC_EN
    logic [15:0] crc_a, crc_b;
`endif

    int checks = 0;
    int errors = 0;
    int exp_bytes = 0;

    logic [7:0] ram [0:255];
    logic [7:0] p1a, p1b, p2b, p3b;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        p1a <= rd_a ? ram[ma_a[7:0]] : 8'hEE;
        p1b <= rd_b ? ram[ma_b[7:0]] : 8'hEE;
        p2b <= p1b;
        p3b <= p2b;
    end
    assign q_a = p1a;
    assign q_b = p3b;

    ioctl_upload_streamer #(.AW(16), .MEM_LAT(1), .IMG_SIZE(256), .FILL(8'hFF)) dut_a (
        .clk_sys(clk), .reset_n(reset_n), .ioctl_upload(upload), .ioctl_rd(rd), .ioctl_addr(addr),
        .ioctl_din(din_a), .ioctl_wait(wait_a), .mem_addr(ma_a), .mem_rd(rd_a), .mem_q(q_a),
        .bytes_sent(bytes_a), .done(done_a), .err(err_a)
`ifdef UPLOAD_CRC_EN
        , .crc(crc_a)
`endif
    );

    ioctl_upload_streamer #(.AW(16), .MEM_LAT(3), .IMG_SIZE(256), .FILL(8'hFF)) dut_b (
        .clk_sys(clk), .reset_n(reset_n), .ioctl_upload(upload), .ioctl_rd(rd), .ioctl_addr(addr),
        .ioctl_din(din_b), .ioctl_wait(wait_b), .mem_addr(ma_b), .mem_rd(rd_b), .mem_q(q_b),
        .bytes_sent(bytes_b), .done(done_b), .err(err_b)
`ifdef UPLOAD_CRC_EN
        , .crc(crc_b)
`endif
    );

    typedef struct {
        logic [24:0] addr;
        logic [7:0]  din;
        int          lat1;
        int          lat3;
        int          rds;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic [24:0] a, input bit dup,
                          output int l1, output int l3, output logic [7:0] d1, output logic [7:0] d3,
                          output int rdc, output logic [15:0] rda);
        l1 = 0; l3 = 0; d1 = 8'h00; d3 = 8'h00; rdc = 0; rda = 16'h0;
        tick();
        rd = 1'b1;
        addr = a;
        tick();
        if (!dup) rd = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (k == 2) rd = 1'b0;
            if (rd_a) begin
                rdc++;
                rda = ma_a;
            end
            if (l1 == 0 && !wait_a) begin
                l1 = k;
                d1 = din_a;
            end
            if (l3 == 0 && !wait_b) begin
                l3 = k;
                d3 = din_b;
            end
            if (l1 != 0 && l3 != 0) break;
            tick();
        end
        rd = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        vec_t        vecs[7];
        int          l1, l3, rdc;
        logic [7:0]  d1, d3;
        logic [15:0] rda;

        vecs[0] = '{addr: 25'd0,          din: 8'h5A, lat1: 3, lat3: 5, rds: 1};
        vecs[1] = '{addr: 25'd1,          din: 8'hA5, lat1: 3, lat3: 5, rds: 1};
        vecs[2] = '{addr: 25'd255,        din: 8'h3C, lat1: 3, lat3: 5, rds: 1};
        vecs[3] = '{addr: 25'd256,        din: 8'hFF, lat1: 2, lat3: 2, rds: 0};
        vecs[4] = '{addr: 25'd300,        din: 8'hFF, lat1: 2, lat3: 2, rds: 0};
        vecs[5] = '{addr: 25'h1000011,    din: 8'hFF, lat1: 2, lat3: 2, rds: 0};
        vecs[6] = '{addr: 25'd17,         din: 8'hC3, lat1: 3, lat3: 5, rds: 1};

        for (int i = 0; i < 256; i++) ram[i] = 8'h00;
        ram[0] = 8'h5A; ram[1] = 8'hA5; ram[2] = 8'h77; ram[17] = 8'hC3; ram[255] = 8'h3C;

        tick(); tick(); tick();
        chk("reset_a", {din_a, wait_a, ma_a, rd_a, bytes_a, done_a, err_a}, 64'h0);
        chk("reset_b", {din_b, wait_b, ma_b, rd_b, bytes_b, done_b, err_b}, 64'h0);
        reset_n = 1'b1;
        upload = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            do_req(vecs[i].addr, 1'b0, l1, l3, d1, d3, rdc, rda);
            exp_bytes++;
            chk($sformatf("v%0d_lat_a", i), l1, vecs[i].lat1);
            chk($sformatf("v%0d_lat_b", i), l3, vecs[i].lat3);
            chk($sformatf("v%0d_din_a", i), d1, vecs[i].din);
            chk($sformatf("v%0d_din_b", i), d3, vecs[i].din);
            chk($sformatf("v%0d_memrd_a", i), rdc, vecs[i].rds);
            chk($sformatf("v%0d_memaddr_a", i), rda, (vecs[i].rds != 0) ? vecs[i].addr[15:0] : 16'h0);
            chk($sformatf("v%0d_bytes_a", i), bytes_a, exp_bytes);
            chk($sformatf("v%0d_bytes_b", i), bytes_b, exp_bytes);
            chk($sformatf("v%0d_err_a", i), err_a, 0);
        end

        // Overlapping request: second strobe lands while the first is in FETCH.
        do_req(25'd2, 1'b1, l1, l3, d1, d3, rdc, rda);
        exp_bytes++;
        chk("dup_lat_a", l1, 3);
        chk("dup_din_a", d1, 8'h77);
        chk("dup_din_b", d3, 8'h77);
        chk("dup_err_a", err_a, 1);
        chk("dup_err_b", err_b, 1);
        chk("dup_bytes_a", bytes_a, exp_bytes);

        upload = 1'b0;
        tick();
        chk("end_done_a", done_a, 1);
        chk("end_err_sticky_a", err_a, 1);
        tick();
        chk("end_done_clear_a", done_a, 0);

        rd = 1'b1;
        addr = 25'd0;
        tick();
        rd = 1'b0;
        chk("noupl_wait_a", wait_a, 0);
        chk("noupl_memrd_a", rd_a, 0);
        tick();

        upload = 1'b1;
        tick();
        exp_bytes = 0;
        chk("start_err_a", err_a, 0);
        chk("start_err_b", err_b, 0);
        chk("start_bytes_a", bytes_a, 0);
        tick();

        // Session drops while instance B is in LAT.
        rd = 1'b1;
        addr = 25'd0;
        tick();
        rd = 1'b0;
        tick();
        upload = 1'b0;
        tick();
        chk("abort_wait_b", wait_b, 0);
        chk("abort_done_b", done_b, 1);
        chk("abort_memrd_b", rd_b, 0);
        chk("abort_wait_a", wait_a, 0);
        tick();
        chk("abort_done_once_b", done_b, 0);
        tick(); tick(); tick();
        chk("abort_wait_late_b", wait_b, 0);
        chk("abort_din_b", din_b, 8'h77);
        chk("abort_bytes_b", bytes_b, exp_bytes);
        chk("abort_bytes_a", bytes_a, exp_bytes);

        // Reset pulse while instance A sits in HOLD.
        upload = 1'b1;
        tick();
        tick();
        rd = 1'b1;
        addr = 25'd1;
        tick();
        rd = 1'b0;
        tick();
        tick();
        chk("hold_din_a", din_a, 8'hA5);
        chk("hold_wait_a", wait_a, 0);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("rst_mid_a", {din_a, wait_a, ma_a, rd_a, bytes_a, done_a, err_a}, 64'h0);
        chk("rst_mid_b", {din_b, wait_b, ma_b, rd_b, bytes_b, done_b, err_b}, 64'h0);
        tick();
        chk("rst_nodone_a", done_a, 0);
        do_req(25'd0, 1'b0, l1, l3, d1, d3, rdc, rda);
        exp_bytes = 1;
        chk("post_rst_din_a", d1, 8'h5A);
        chk("post_rst_lat_b", l3, 5);
        chk("post_rst_bytes_a", bytes_a, exp_bytes);

`ifdef UPLOAD_CRC_EN
        upload = 1'b0;
        tick();
        upload = 1'b1;
        tick();
        chk("crc_init_a", crc_a, 16'hFFFF);
        for (int i = 0; i < 9; i++) ram[i] = 8'h31 + 8'(i);
        for (int i = 0; i < 9; i++) begin
            do_req(25'(i), 1'b0, l1, l3, d1, d3, rdc, rda);
        end
        upload = 1'b0;
        tick();
        chk("crc_done_a", done_a, 1);
        chk("crc_val_a", crc_a, 16'h29B1);
        chk("crc_val_b", crc_b, 16'h29B1);
        chk("crc_bytes_a", bytes_a, 9);
        tick();
        chk("crc_hold_a", crc_a, 16'h29B1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
